// File: rtl/vga_fb_arbiter.sv
// rtl/vga_fb_arbiter.sv - blanking-aware arbiter sharing one framebuffer SRAM between display fetch and host
// Display owns the slot in active video; host owns it in blanking unless a deferred display request is forced.
module vga_fb_arbiter #(
   parameter int ADDR_W        = 19,
   parameter int DATA_W        = 16,
   parameter int DISP_MAX_WAIT = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              active_video,
   input  logic              disp_req,
   input  logic [ADDR_W-1:0] disp_addr,
   output logic              disp_gnt,
   output logic              disp_rvalid,
   output logic [DATA_W-1:0] disp_rdata,
   output logic              disp_forced,
   input  logic              host_valid,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   output logic              host_ready,
   output logic              host_rvalid,
   output logic [DATA_W-1:0] host_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int                WAIT_W   = 8;
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(DISP_MAX_WAIT);

   typedef enum logic [1:0] {
      OWN_IDLE    = 2'd0,
      OWN_DISP_RD = 2'd1,
      OWN_HOST_RD = 2'd2,
      OWN_HOST_WR = 2'd3
   } owner_e;

   owner_e            own_q, own_d, own_dly_q;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              force_w;
   logic              host_fire;

   logic              mem_en_q, mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;
   logic              disp_rvalid_q, host_rvalid_q, disp_forced_q;
   logic [DATA_W-1:0] disp_rdata_q, host_rdata_q;

   assign force_w   = (wait_q == WAIT_MAX);
   assign host_fire = host_valid & host_ready;

   // Owner pipeline: own_q tracks the access on the SRAM port, own_dly_q the cycle its data returns.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         own_q     <= OWN_IDLE;
         own_dly_q <= OWN_IDLE;
      end else begin
         own_q     <= own_d;
         own_dly_q <= own_q;
      end
   end

   always_comb begin
      own_d = OWN_IDLE;
      if (disp_gnt) begin
         own_d = OWN_DISP_RD;
      end else if (host_fire) begin
         own_d = host_we ? OWN_HOST_WR : OWN_HOST_RD;
      end
   end

   always_comb begin
      disp_gnt   = 1'b0;
      host_ready = 1'b0;
      if (active_video) begin
         disp_gnt   = disp_req;
         host_ready = !disp_req;
      end else begin
         disp_gnt   = disp_req & (!host_valid | force_w);
         host_ready = !(disp_req & force_w);
      end
   end

   // Counts consecutive refused cycles of a pending display request; a toggle of active_video does not clear it.
   always_comb begin
      wait_d = '0;
      if (disp_req && !disp_gnt) begin
         wait_d = force_w ? wait_q : wait_q + WAIT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_q        <= '0;
         mem_en_q      <= 1'b0;
         mem_we_q      <= 1'b0;
         mem_addr_q    <= '0;
         mem_wdata_q   <= '0;
         disp_forced_q <= 1'b0;
         disp_rvalid_q <= 1'b0;
         disp_rdata_q  <= '0;
         host_rvalid_q <= 1'b0;
         host_rdata_q  <= '0;
      end else begin
         wait_q        <= wait_d;
         mem_en_q      <= disp_gnt | host_fire;
         mem_we_q      <= host_fire & host_we;
         disp_forced_q <= force_w & disp_gnt & host_valid & !active_video;
         if (disp_gnt) begin
            mem_addr_q <= disp_addr;
         end else if (host_fire) begin
            mem_addr_q  <= host_addr;
            mem_wdata_q <= host_wdata;
         end
         disp_rvalid_q <= (own_dly_q == OWN_DISP_RD);
         host_rvalid_q <= (own_dly_q == OWN_HOST_RD);
         if (own_dly_q == OWN_DISP_RD) begin
            disp_rdata_q <= mem_rdata;
         end
         if (own_dly_q == OWN_HOST_RD) begin
            host_rdata_q <= mem_rdata;
         end
      end
   end

   assign mem_en      = mem_en_q;
   assign mem_we      = mem_we_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign disp_forced = disp_forced_q;
   assign disp_rvalid = disp_rvalid_q;
   assign disp_rdata  = disp_rdata_q;
   assign host_rvalid = host_rvalid_q;
   assign host_rdata  = host_rdata_q;

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Shares one single-port framebuffer SRAM between the VGA display fetcher and a host (CPU/DMA) port.
- Sits between the 640x480@60 timing generator, the line fetcher and the framebuffer memory.
- Priority is blanking-aware:
  - During active video the display always wins.
  - During blanking the host wins, with a bounded-wait override that protects display prefetch.

Parameters:
ADDR_W, 19, framebuffer word-address width (covers 640*480 words)
DATA_W, 16, framebuffer word width
DISP_MAX_WAIT, 8, blanking cycles a pending display request may be deferred before it is forced (1..255)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
active_video  in  1  high while the timing generator is in the display region (h<640 and v<480)
disp_req  in  1  display read request; held with disp_addr until disp_gnt
disp_addr  in  ADDR_W  display read address
disp_gnt  out  1  combinational grant; request consumed this cycle
disp_rvalid  out  1  registered; disp_rdata valid
disp_rdata  out  DATA_W  registered display read data
disp_forced  out  1  registered 1-cycle pulse: display grant was forced over a waiting host in blanking
host_valid  in  1  host request valid
host_we  in  1  1=write, 0=read
host_addr  in  ADDR_W  host address
host_wdata  in  DATA_W  host write data
host_ready  out  1  combinational; transfer occurs when host_valid and host_ready
host_rvalid  out  1  registered; host_rdata valid (reads only)
host_rdata  out  DATA_W  registered host read data
mem_en  out  1  registered SRAM enable
mem_we  out  1  registered SRAM write enable
mem_addr  out  ADDR_W  registered SRAM address
mem_wdata  out  DATA_W  registered SRAM write data
mem_rdata  in  DATA_W  SRAM read data, valid the cycle after mem_en with mem_we=0

Behaviour:
- Reset (async assert, sync release): all registered outputs 0, wait counter 0, owner pipeline IDLE. In-flight reads are dropped: no rvalid for any access issued before reset.
- Arbitration in cycle t (combinational). force = (disp_wait == DISP_MAX_WAIT).
  - active_video=1: disp_gnt = disp_req; host_ready = !disp_req.
  - active_video=0: disp_gnt = disp_req & (!host_valid | force); host_ready = !(disp_req & force).
  - At most one of (disp_gnt, host_valid&host_ready) per cycle.
- Wait counter:
  - Increments when disp_req & !disp_gnt, saturating at DISP_MAX_WAIT.
  - Clears on disp_gnt or when disp_req=0.
- disp_forced = 1 in t+1 when force & disp_gnt & host_valid & !active_video.
- Owner state (registered at t+1): IDLE, DISP_RD, HOST_RD, HOST_WR.
  - Granted op at t produces mem_en=1 at t+1, with mem_addr/mem_we/mem_wdata from the winner.
  - DISP grants: mem_we=0.
  - No grant at t: mem_en=0 at t+1.
- Read return:
  - Owner DISP_RD or HOST_RD at t+1 moves to an owner-delayed register at t+2, when mem_rdata is captured.
  - Matching rvalid and rdata are asserted at t+3. Read latency is 3 cycles from grant.
  - Host writes produce no rvalid.
  - Back-to-back grants every cycle give full throughput; the return pipeline keeps per-access order.
- Outside active_video (blanking), the display is bounded to DISP_MAX_WAIT+1 cycles from request to grant.
- active_video toggling mid-wait: rules apply per cycle; the counter is not cleared by the toggle.

Test Plan:
- Reset mid-operation: rst_n low in the cycle after a host read grant -> all outputs 0 immediately; no host_rvalid after release; mem_en=0.
- Active-video contention: active_video=1, disp_req and host_valid (read 0x00010) simultaneously for 4 cycles -> disp_gnt=1 each cycle, host_ready=0. Then disp_req drops -> host_ready=1, host_rvalid 3 cycles later with the preloaded data 0xBEEF.
- Blanking host priority: active_video=0, host_valid continuous writes, disp_req held at 0x12C00 with DISP_MAX_WAIT=8 -> host_ready=1 for 8 cycles. Cycle 9: disp_gnt=1, host_ready=0; disp_forced pulse next cycle; counter back to 0.
- Read latency/order: alternating disp read 0x00000 and host read 0x00001, one grant per cycle -> mem_en every cycle; disp_rvalid/host_rvalid alternate, each exactly 3 cycles after its grant with the correct data.
- Idle/no-grant: no requests for 10 cycles -> mem_en=0 and no rvalid. A host write of 0x5A5A to 0x00020 -> mem_en=mem_we=1, addr 0x00020 at t+1; no host_rvalid.
